// File: rtl/inst_queue_if.sv
// Fetch-to-decode instruction queue bus: fetch pair in, two show-ahead entries out.
interface inst_queue_if #(
    parameter int DEPTH = 8,
    parameter int CW    = $clog2(DEPTH) + 1
);
    logic          flush;
    logic          in_valid;
    logic [31:0]   in_pc;
    logic [31:0]   in_inst1;
    logic [31:0]   in_inst2;
    logic          in_ready;
    logic          out_valid0;
    logic          out_valid1;
    logic [31:0]   out_inst0;
    logic [31:0]   out_inst1;
    logic [31:0]   out_pc0;
    logic [31:0]   out_pc1;
    logic [1:0]    out_take;
    logic [CW-1:0] count;

    modport slave (
        input  flush, in_valid, in_pc, in_inst1, in_inst2, out_take,
        output in_ready, out_valid0, out_valid1, out_inst0, out_inst1,
               out_pc0, out_pc1, count
    );

    modport master (
        output flush, in_valid, in_pc, in_inst1, in_inst2, out_take,
        input  in_ready, out_valid0, out_valid1, out_inst0, out_inst1,
               out_pc0, out_pc1, count
    );
endinterface

// File: rtl/inst_queue.sv
// Circular instruction queue: enqueues fetch pairs, presents head/head+1 show-ahead.
// Optional build macro INST_QUEUE_ZERO_FILTER_EN drops all-zero instruction words on enqueue.
module inst_queue #(
    parameter int DEPTH = 8,
    parameter int CW    = $clog2(DEPTH) + 1
) (
    input  logic        clk,
    input  logic        rst_n,
    inst_queue_if.slave q
);
    localparam int AW = $clog2(DEPTH);

    logic [31:0]   inst_q [DEPTH];
    logic [31:0]   pc_q   [DEPTH];
    logic [AW-1:0] head_q, head_d;
    logic [AW-1:0] tail_q, tail_d;
    logic [CW-1:0] count_q, count_d;

    logic          ready;
    logic          enq_fire;
    logic [1:0]    take_eff;
    logic [1:0]    deq_n;
    logic [1:0]    enq_n;
    logic          wr0_en, wr1_en;
    logic [31:0]   wr0_inst, wr0_pc, wr1_inst, wr1_pc;
    logic [AW-1:0] tail_p1, head_p1;
    logic [DEPTH-1:0] we0, we1;

    // Ready looks only at the registered count; a same-cycle dequeue earns no credit.
    assign ready    = (count_q <= CW'(DEPTH - 2));
    assign enq_fire = q.in_valid && ready && !q.flush;
    assign tail_p1  = tail_q + AW'(1);
    assign head_p1  = head_q + AW'(1);

    always_comb begin
        take_eff = (q.out_take == 2'd3) ? 2'd2 : q.out_take;
        deq_n    = take_eff;
        if (CW'(take_eff) > count_q) begin
            deq_n = count_q[1:0];
        end
    end

`ifdef INST_QUEUE_ZERO_FILTER_EN
    logic nz1, nz2;
    // Nonzero words are packed from tail in program order.
    always_comb begin
        nz1      = |q.in_inst1;
        nz2      = |q.in_inst2;
        wr0_en   = enq_fire && (nz1 || nz2);
        wr0_inst = nz1 ? q.in_inst1 : q.in_inst2;
        wr0_pc   = nz1 ? q.in_pc : (q.in_pc + 32'd4);
        wr1_en   = enq_fire && nz1 && nz2;
        wr1_inst = q.in_inst2;
        wr1_pc   = q.in_pc + 32'd4;
    end
`else
    always_comb begin
        wr0_en   = enq_fire;
        wr0_inst = q.in_inst1;
        wr0_pc   = q.in_pc;
        wr1_en   = enq_fire;
        wr1_inst = q.in_inst2;
        wr1_pc   = q.in_pc + 32'd4;
    end
`endif

    assign enq_n = {1'b0, wr0_en} + {1'b0, wr1_en};

    always_comb begin
        head_d  = head_q + AW'(deq_n);
        tail_d  = tail_q + AW'(enq_n);
        count_d = count_q + CW'(enq_n) - CW'(deq_n);
        if (q.flush) begin
            head_d  = '0;
            tail_d  = '0;
            count_d = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < DEPTH; gi++) begin : g_we
            assign we0[gi] = wr0_en && (tail_q == AW'(gi));
            assign we1[gi] = wr1_en && (tail_p1 == AW'(gi));
        end
    endgenerate

    always_ff @(posedge clk) begin
        for (int i = 0; i < DEPTH; i++) begin
            if (!rst_n) begin
                inst_q[i] <= '0;
                pc_q[i]   <= '0;
            end else if (we0[i]) begin
                inst_q[i] <= wr0_inst;
                pc_q[i]   <= wr0_pc;
            end else if (we1[i]) begin
                inst_q[i] <= wr1_inst;
                pc_q[i]   <= wr1_pc;
            end
        end
    end

    assign q.in_ready   = ready;
    assign q.count      = count_q;
    assign q.out_valid0 = (count_q != '0);
    assign q.out_valid1 = (count_q >= CW'(2));
    assign q.out_inst0  = q.out_valid0 ? inst_q[head_q]  : 32'd0;
    assign q.out_pc0    = q.out_valid0 ? pc_q[head_q]    : 32'd0;
    assign q.out_inst1  = q.out_valid1 ? inst_q[head_p1] : 32'd0;
    assign q.out_pc1    = q.out_valid1 ? pc_q[head_p1]   : 32'd0;
endmodule

// File: doc/inst_queue.md
INST_QUEUE -- requirements
Module: inst_queue

Interface
REQ-001 SHALL provide parameter DEPTH, default 8, entry count (power of two, >=4).
REQ-002 SHALL provide parameter CW, default $clog2(DEPTH)+1, width of count output.
REQ-003 clk  input  1  single clock, all state updates on posedge.
REQ-004 rst_n  input  1  reset, synchronous, active-low.
REQ-005 flush  input  1  discard all queued entries (branch redirect).
REQ-006 in_valid  input  1  fetch pair presented this cycle.
REQ-007 in_pc  input  32  byte address of in_inst1; in_inst2 is at in_pc+4.
REQ-008 in_inst1  input  32  first fetched word.
REQ-009 in_inst2  input  32  second fetched word.
REQ-010 in_ready  output  1  queue can accept a full pair; PC generator stalls when low.
REQ-011 out_valid0 / out_valid1  output  1 each  head / head+1 entry valid.
REQ-012 out_inst0 / out_inst1  output  32 each  instruction at head / head+1.
REQ-013 out_pc0 / out_pc1  output  32 each  pc at head / head+1.
REQ-014 out_take  input  2  entries consumed by decode this cycle (0, 1 or 2; 3 treated as 2).
REQ-015 count  output  CW  number of valid entries.

Function
REQ-016 Storage SHALL be a circular buffer of DEPTH {inst,pc} entries with head and tail pointers wrapping modulo DEPTH.
REQ-017 in_ready SHALL be 1 when DEPTH-count >= 2, computed from the registered count only (no same-cycle dequeue credit).
REQ-018 Enqueue SHALL occur when in_valid && in_ready && !flush: {in_inst1,in_pc} to tail, {in_inst2,in_pc+4} to tail+1, tail += 2.
REQ-019 in_valid while in_ready=0 SHALL be ignored with no state change; upstream holds the pair.
REQ-020 Outputs SHALL be show-ahead (combinational from head): out_valid0 = count>=1, out_valid1 = count>=2; inst/pc fields SHALL read 0 when the corresponding valid is 0.
REQ-021 Dequeue amount SHALL be min(out_take, count); head advances by that amount modulo DEPTH.
REQ-022 Simultaneous enqueue and dequeue SHALL yield count_next = count + enq_n - deq_n in one cycle.
REQ-023 flush SHALL take priority over enqueue and dequeue: next cycle head=tail=0, count=0, and the pair presented with flush is dropped.
REQ-024 Latency: an enqueued entry SHALL appear on out_* the cycle after the enqueue edge.
REQ-025 Pointer arithmetic SHALL use log2(DEPTH) bits; count SHALL never exceed DEPTH or go below 0.

Reset
REQ-026 When rst_n=0 at posedge clk: head=0, tail=0, count=0, all storage entries cleared to 0.
REQ-027 During and after reset: in_ready=1, out_valid0=out_valid1=0, out_inst*/out_pc*=0; reset mid-operation discards all entries identically to REQ-026.

Configuration
REQ-028 Macro INST_QUEUE_ZERO_FILTER_EN, when defined, SHALL suppress enqueue of all-zero instruction words (empty-memory fill): only nonzero words are written, packed contiguously from tail in order, tail and count advance by 0, 1 or 2.
REQ-029 With INST_QUEUE_ZERO_FILTER_EN undefined, both words SHALL be enqueued unconditionally per REQ-018; in_ready rule (REQ-017) is identical in both builds.

Verification
REQ-030 Reset then in_valid=1, in_pc=0x0, in_inst1=0x00500093, in_inst2=0x00A00113, out_take=0 -> next cycle count=2, out_pc0=0x0, out_pc1=0x4, out_valid0=out_valid1=1.
REQ-031 Fill DEPTH=8 with 4 pairs, out_take=0 -> count=8, in_ready=0; further in_valid ignored; then out_take=2 one cycle -> count=6, in_ready=1.
REQ-032 count=7, in_valid=1 with out_take=2 -> in_ready=0 so pair dropped, count=5 next cycle; pointers wrap correctly over 3 full laps with pc order preserved.
REQ-033 count=5, flush=1 with in_valid=1 and out_take=2 -> next cycle count=0, out_valid0=0, in_ready=1.
REQ-034 Filter build: in_inst1=0, in_inst2=0x00208233, in_pc=0x10 -> count +1, entry pc=0x14; both zero -> count unchanged; non-filter build same stimulus -> count +2.
REQ-035 count=1, out_take=2 -> dequeues 1, count=0; rst_n=0 mid-stream with count=6 -> count=0, outputs 0 next cycle.
